// File: rtl/he_pkg.sv
// Shared types and constants for the histogram-equalization output stage.
package he_pkg;

    // Packer frame state: waiting for SOF, or inside a frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Default frame geometry.
    localparam int IMG_WIDTH_DEFAULT  = 512;
    localparam int IMG_HEIGHT_DEFAULT = 512;
    localparam int NUM_PIXELS_DEFAULT = IMG_WIDTH_DEFAULT * IMG_HEIGHT_DEFAULT;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;

endpackage

// File: rtl/he_word_packer_if.sv
// Pixel-in / word-out bus of the word packer.
interface he_word_packer_if;
    import he_pkg::*;

    logic              pix_valid;
    logic              pix_sof;
    logic [PIX_W-1:0]  pix_in;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_last;

    // Environment side: produces pixels, consumes words.
    modport master (
        output pix_valid, pix_sof, pix_in, word_ready,
        input  word_valid, word_data, word_last
    );

    // Packer side: consumes pixels, produces words.
    modport slave (
        input  pix_valid, pix_sof, pix_in, word_ready,
        output word_valid, word_data, word_last
    );

endinterface

// File: rtl/he_sync_fifo.sv
// Synchronous FIFO with a registered head entry. The oldest word lives in
// head_q so the output never depends combinationally on the write side;
// the remaining DEPTH-1 entries sit in a small ring behind it.
module he_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int RING_N = DEPTH - 1;
    localparam int PTR_W  = (RING_N > 1) ? $clog2(RING_N) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] ring_q [RING_N];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push_en;
    logic pop_en;
    logic head_from_din;
    logic head_from_ring;
    logic ring_we;

    // Ring pointers wrap at RING_N, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RING_N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = head_q;

    // Route the incoming word to the head or the ring, and refill the head on pop.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        pop_en         = pop && !empty;
        push_en        = push && (!full || pop_en);
        head_from_din  = push_en && (empty || (pop_en && count_q == CNT_W'(1)));
        head_from_ring = pop_en && (count_q > CNT_W'(1));
        ring_we        = push_en && !head_from_din;
    end

    // Head register, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking, so head_q reads the ring entry as it was before this edge.
            if (head_from_din) begin
                head_q <= din;
            end else if (head_from_ring) begin
                head_q <= ring_q[rd_ptr_q];
            end
            if (head_from_ring) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            if (ring_we) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Ring storage write port.
    // NOTE: storage is not reset; count_q already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/he_word_packer.sv
// Packs four consecutive equalized pixels into a 32-bit word, flags the
// final word of each frame, and queues words for the frame-buffer writer.
module he_word_packer
    import he_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    he_word_packer_if.slave  io,
    output logic             frame_done,
    output logic             overflow,
    output logic             frame_err
);
    // Frame size must be a multiple of 4 so the last pixel lands in lane 3.
    localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W      = $clog2(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

    state_t             state_q;
    logic [1:0]         lane_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3*PIX_W-1:0] sreg_q;     // lanes 0..2; lane 3 comes straight from pix_in

    logic              push;
    logic              push_last;
    logic [WORD_W:0]   push_word;
    logic [WORD_W:0]   fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    assign push_word = {push_last, io.pix_in, sreg_q};
    assign pop       = !fifo_empty && io.word_ready;
    assign drop      = push && fifo_full && !pop;

    assign io.word_valid = !fifo_empty;
    assign io.word_data  = fifo_dout[WORD_W-1:0];
    assign io.word_last  = fifo_dout[WORD_W];

    // A word completes when a non-SOF pixel fills lane 3 inside a frame.
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        if (state_q == ACTIVE && io.pix_valid && !io.pix_sof && lane_q == 2'd3) begin
            push      = 1'b1;
            push_last = (cnt_q == LAST_CNT);
        end
    end

    he_sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame FSM, lane/pixel counters, shift register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            cnt_q      <= '0;
            sreg_q     <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= pop && fifo_dout[WORD_W];

            if (drop) begin
                overflow <= 1'b1;
                // Losing the last word truncates the frame as seen downstream.
                if (push_last) begin
                    frame_err <= 1'b1;
                end
            end

            if (io.pix_valid) begin
                if (io.pix_sof) begin
                    // SOF always starts a fresh frame; mid-frame it discards the partial word.
                    if (state_q == ACTIVE) begin
                        frame_err <= 1'b1;
                    end
                    sreg_q[PIX_W-1:0] <= io.pix_in;
                    lane_q            <= 2'd1;
                    cnt_q             <= CNT_W'(1);
                    state_q           <= ACTIVE;
                end else if (state_q == ACTIVE) begin
                    if (lane_q == 2'd3) begin
                        lane_q <= 2'd0;
                        if (push_last) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        sreg_q[lane_q*PIX_W +: PIX_W] <= io.pix_in;
                        lane_q <= lane_q + 2'd1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_he_word_packer.sv
// Self-checking bench for he_word_packer on a 4x4 frame with a 4-deep FIFO.
module tb_he_word_packer;
    import he_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int NUM   = W * H;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    logic frame_done;
    logic overflow;
    logic frame_err;

    he_word_packer_if bus();

    he_word_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .io         (bus),
        .frame_done (frame_done),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pixels are collected four at a time; a frame is NUM pixels after SOF.
    // The FIFO is a queue of words bounded at DEPTH.
    byte unsigned part_q[$];
    word_t        exp_q[$];
    int           pix_idx  = 0;
    bit           in_frame = 0;
    bit           exp_done = 0;
    bit           exp_ovf  = 0;
    bit           exp_err  = 0;
    bit           m_popped;
    bit           m_full;
    bit           m_have;
    word_t        m_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            part_q.delete();
            exp_q.delete();
            pix_idx  = 0;
            in_frame = 0;
            exp_done = 0;
            exp_ovf  = 0;
            exp_err  = 0;
        end else begin
            m_popped = (exp_q.size() > 0) && bus.word_ready;
            m_full   = (exp_q.size() == DEPTH);
            exp_done = 0;
            if (m_popped && exp_q[0].last) exp_done = 1;
            m_have = 0;
            if (bus.pix_valid) begin
                if (bus.pix_sof) begin
                    if (in_frame) exp_err = 1;
                    part_q.delete();
                    part_q.push_back(bus.pix_in);
                    pix_idx  = 1;
                    in_frame = 1;
                end else if (in_frame) begin
                    part_q.push_back(bus.pix_in);
                    pix_idx++;
                    if (part_q.size() == 4) begin
                        m_word.data = {part_q[3], part_q[2], part_q[1], part_q[0]};
                        m_word.last = (pix_idx == NUM);
                        m_have      = 1;
                        part_q.delete();
                        if (m_word.last) in_frame = 0;
                    end
                end
            end
            if (m_popped) void'(exp_q.pop_front());
            if (m_have) begin
                if (m_full && !m_popped) begin
                    exp_ovf = 1;
                    if (m_word.last) exp_err = 1;
                end else begin
                    exp_q.push_back(m_word);
                end
            end
        end
    end

    // Words actually handed over by the DUT, for the literal checks.
    word_t got_q[$];
    int    done_cnt = 0;

    always @(posedge clk) begin
        if (!reset && bus.word_valid && bus.word_ready)
            got_q.push_back({bus.word_last, bus.word_data});
    end

    // Compare the DUT with the model on every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("word_valid", 33'(bus.word_valid), 33'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("word_data", 33'(bus.word_data), 33'(exp_q[0].data));
                check("word_last", 33'(bus.word_last), 33'(exp_q[0].last));
            end
            check("frame_done", 33'(frame_done), 33'(exp_done));
            check("overflow", 33'(overflow), 33'(exp_ovf));
            check("frame_err", 33'(frame_err), 33'(exp_err));
            if (frame_done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic sof, input logic [7:0] v);
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_in    = v;
        step();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic apply_reset();
        bus.word_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic drain();
        bus.word_ready = 1'b1;
        for (int i = 0; i < 64 && bus.word_valid; i++) step();
        check("drain_empty", 33'(bus.word_valid), 33'(0));
        repeat (3) step();
    endtask

    function automatic word_t got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : '0;
    endfunction

    int stim_cnt;
    bit bad_byte;

    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_sof    = 1'b0;
        bus.pix_in     = '0;
        bus.word_ready = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        step();
        check("rst_word_valid", 33'(bus.word_valid), 33'(0));
        check("rst_word_data", 33'(bus.word_data), 33'(0));
        check("rst_word_last", 33'(bus.word_last), 33'(0));
        check("rst_frame_done", 33'(frame_done), 33'(0));
        check("rst_overflow", 33'(overflow), 33'(0));
        check("rst_frame_err", 33'(frame_err), 33'(0));
        reset = 1'b0;

        // Full frame, pixels 0..15, ready held high.
        bus.word_ready = 1'b1;
        for (int i = 0; i < NUM; i++) pix(i == 0, 8'(i));
        repeat (4) step();
        check("f1_count", 33'(got_q.size()), 33'(4));
        check("f1_w0", 33'(got_at(0)), {1'b0, 32'h03020100});
        check("f1_w1", 33'(got_at(1)), {1'b0, 32'h07060504});
        check("f1_w2", 33'(got_at(2)), {1'b0, 32'h0B0A0908});
        check("f1_w3", 33'(got_at(3)), {1'b1, 32'h0F0E0D0C});
        check("f1_done_pulses", 33'(done_cnt), 33'(1));
        check("f1_overflow", 33'(overflow), 33'(0));

        // Backpressure: two frames (8 words) into a stalled 4-deep FIFO.
        apply_reset();
        for (int i = 0; i < 2 * NUM; i++) pix(i % NUM == 0, 8'(8'h20 + i));
        check("bp_overflow", 33'(overflow), 33'(1));
        check("bp_frame_err", 33'(frame_err), 33'(1));
        check("bp_head", 33'(bus.word_data), 33'(32'h23222120));
        drain();
        check("bp_count", 33'(got_q.size()), 33'(4));
        check("bp_w0", 33'(got_at(0)), {1'b0, 32'h23222120});
        check("bp_w3", 33'(got_at(3)), {1'b1, 32'h2F2E2D2C});

        // SOF after 6 pixels, then a full frame starting at 0x40.
        apply_reset();
        bus.word_ready = 1'b1;
        for (int i = 0; i < 6; i++) pix(i == 0, 8'(8'h30 + i));
        for (int i = 0; i < NUM; i++) pix(i == 0, 8'(8'h40 + i));
        drain();
        check("sof_frame_err", 33'(frame_err), 33'(1));
        check("sof_count", 33'(got_q.size()), 33'(5));
        check("sof_w0", 33'(got_at(0)), {1'b0, 32'h33323130});
        check("sof_w1", 33'(got_at(1)), {1'b0, 32'h43424140});
        check("sof_w4", 33'(got_at(4)), {1'b1, 32'h4F4E4D4C});

        // Pixels without SOF while idle are ignored.
        apply_reset();
        bus.word_ready = 1'b1;
        for (int i = 0; i < 7; i++) pix(1'b0, 8'hAA);
        for (int i = 0; i < NUM; i++) pix(i == 0, 8'(8'h50 + i));
        drain();
        bad_byte = 0;
        foreach (got_q[k])
            for (int b = 0; b < 4; b++)
                if (got_q[k].data[8*b +: 8] == 8'hAA) bad_byte = 1;
        check("idle_no_aa", 33'(bad_byte), 33'(0));
        check("idle_count", 33'(got_q.size()), 33'(4));
        check("idle_w0", 33'(got_at(0)), {1'b0, 32'h53525150});

        // Asynchronous reset with two words queued.
        apply_reset();
        for (int i = 0; i < 8; i++) pix(i == 0, 8'(8'h70 + i));
        check("ar_valid_before", 33'(bus.word_valid), 33'(1));
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid_now", 33'(bus.word_valid), 33'(0));
        check("ar_data_now", 33'(bus.word_data), 33'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        bus.word_ready = 1'b1;
        for (int i = 0; i < NUM; i++) pix(i == 0, 8'(8'h80 + i));
        drain();
        check("ar_count", 33'(got_q.size()), 33'(4));
        check("ar_w0", 33'(got_at(0)), {1'b0, 32'h83828180});

        // Push and pop on the same edge with the FIFO full.
        apply_reset();
        for (int i = 0; i < NUM; i++) pix(i == 0, 8'(i));
        pix(1'b1, 8'h60);
        pix(1'b0, 8'h61);
        pix(1'b0, 8'h62);
        bus.word_ready = 1'b1;
        pix(1'b0, 8'h63);
        bus.word_ready = 1'b0;
        check("pp_overflow", 33'(overflow), 33'(0));
        check("pp_head", 33'(bus.word_data), 33'(32'h07060504));
        drain();
        check("pp_count", 33'(got_q.size()), 33'(5));
        check("pp_w0", 33'(got_at(0)), {1'b0, 32'h03020100});
        check("pp_w3", 33'(got_at(3)), {1'b1, 32'h0F0E0D0C});
        check("pp_w4", 33'(got_at(4)), {1'b0, 32'h63626160});

        // Randomized traffic: gaps, stalls, stray and mid-frame SOFs.
        apply_reset();
        stim_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 < 40) bus.word_ready = 1'b0;
            else bus.word_ready = ($urandom_range(0, 3) != 0);
            bus.pix_valid = ($urandom_range(0, 9) < 8);
            if (stim_cnt % NUM == 0) bus.pix_sof = ($urandom_range(0, 4) != 0);
            else bus.pix_sof = ($urandom_range(0, 150) == 0);
            bus.pix_in = 8'($urandom);
            if (bus.pix_valid) stim_cnt = bus.pix_sof ? 1 : stim_cnt + 1;
            step();
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
